// File: rtl/rsa_modexp_ctrl_pkg.sv
// Shared types and defaults for the RSA modular exponentiation sequencer.
package rsa_modexp_ctrl_pkg;
    localparam int DEF_W  = 8;
    localparam int DEF_EW = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MUL_R = 3'd2,
        MUL_B = 3'd3,
        DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/rsa_modmul_serial.sv
// Bit-serial modular multiplier: p = a*b mod n, MSB of b first, W cycles.
module rsa_modmul_serial #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] p
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          run;

    logic [CW-1:0] idx;
    logic [W-1:0]  acc_cur;
    logic [W:0]    nn, dbl, red1, add, red2, sum;

    // go marks the first step, so the product is ready after exactly W cycles
    assign idx     = go ? CW'(W - 1) : cnt;
    assign acc_cur = go ? '0 : acc;
    assign nn      = {1'b0, n};
    assign dbl     = {acc_cur, 1'b0};
    assign red1    = (dbl >= nn) ? dbl - nn : dbl;
    assign add     = red1 + {1'b0, a};
    assign red2    = (add >= nn) ? add - nn : add;
    assign sum     = b[idx] ? red2 : red1;

    assign p    = sum[W-1:0];
    assign busy = run;
    assign done = (go | run) && (idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (go) begin
            acc <= p;
            cnt <= CW'(W - 2);
            run <= 1'b1;
        end else if (run) begin
            acc <= p;
            if (cnt == '0)
                run <= 1'b0;
            else
                cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer: result = msg^exp mod mod_n.
module rsa_modexp_ctrl
    import rsa_modexp_ctrl_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int EW = DEF_EW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  msg,
    input  logic [EW-1:0] exp,
    input  logic [W-1:0]  mod_n,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          err
);
    state_t state, nxt;

    logic [W-1:0]  base, res, n_r;
    logic [EW-1:0] e;

    logic ld_in, ld_res, ld_base, ld_out, out_err, sel_r;
    logic mm_go, mm_busy, mm_done;
    logic [W-1:0] mm_a, mm_p;

    always_comb begin
        nxt     = state;
        ld_in   = 1'b0;
        ld_res  = 1'b0;
        ld_base = 1'b0;
        ld_out  = 1'b0;
        out_err = 1'b0;
        sel_r   = 1'b0;
        mm_go   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    ld_in = 1'b1;
                    nxt   = CHECK;
                end
            end
            CHECK: begin
                // base >= n can only hold on the first visit; squares stay < n
                if (n_r < W'(2) || base >= n_r) begin
                    ld_out  = 1'b1;
                    out_err = 1'b1;
                    nxt     = DONE;
                end else if (e == '0) begin
                    ld_out = 1'b1;
                    nxt    = DONE;
                end else if (e[0]) begin
                    nxt = MUL_R;
                end else begin
                    nxt = MUL_B;
                end
            end
            MUL_R: begin
                sel_r = 1'b1;
                mm_go = !mm_busy;
                if (mm_done) begin
                    ld_res = 1'b1;
                    nxt    = MUL_B;
                end
            end
            MUL_B: begin
                mm_go = !mm_busy;
                if (mm_done) begin
                    ld_base = 1'b1;
                    nxt     = CHECK;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            base   <= '0;
            res    <= '0;
            e      <= '0;
            n_r    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state <= nxt;
            if (ld_in) begin
                base <= msg;
                res  <= W'(1);
                e    <= exp;
                n_r  <= mod_n;
            end
            if (ld_res)
                res <= mm_p;
            if (ld_base) begin
                base <= mm_p;
                e    <= e >> 1;
            end
            if (ld_out) begin
                result <= out_err ? '0 : res;
                err    <= out_err;
            end
        end
    end

    assign mm_a = sel_r ? res : base;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    rsa_modmul_serial #(
        .W(W)
    ) u_mul (
        .clk  (clk),
        .rst_n(rst_n),
        .go   (mm_go),
        .a    (mm_a),
        .b    (base),
        .n    (n_r),
        .busy (mm_busy),
        .done (mm_done),
        .p    (mm_p)
    );
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Randomized bench for rsa_modexp_ctrl against a cycle-level behavioural model.
module tb_rsa_modexp_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] msg = '0, expo = '0, mod_n = '0;
    logic       busy, done, err;
    logic [7:0] result;

    int checks = 0;
    int failures = 0;

    rsa_modexp_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .msg   (msg),
        .exp   (expo),
        .mod_n (mod_n),
        .busy  (busy),
        .done  (done),
        .result(result),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic bit ref_err(input int m, input int n);
        return (n < 2) || (m >= n);
    endfunction

    function automatic int ref_res(input int m, input int e, input int n);
        int r;
        if (ref_err(m, n)) return 0;
        r = 1 % n;
        for (int i = 0; i < e; i++) r = (r * m) % n;
        return r;
    endfunction

    function automatic int ref_lat(input int m, input int e, input int n);
        int l;
        if (ref_err(m, n)) return 1;
        l = 1;
        for (int i = 0; i < 8; i++)
            if ((e >> i) != 0) l += 1 + 8 + 8 * ((e >> i) & 1);
        return l;
    endfunction

    // Behavioural model: idle/busy, countdown to done, held result/err
    bit m_busy, m_done, m_err, p_err;
    int m_cnt, m_result, p_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_err <= 0;
            m_result <= 0; m_cnt <= 0; p_res <= 0; p_err <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1;
                m_cnt  <= ref_lat(msg, expo, mod_n);
                p_res  <= ref_res(msg, expo, mod_n);
                p_err  <= ref_err(msg, mod_n);
            end
        end else if (m_done) begin
            m_done <= 0;
            m_busy <= 0;
        end else begin
            if (m_cnt == 1) begin
                m_done   <= 1;
                m_result <= p_res;
                m_err    <= p_err;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("result", result, m_result);
            check("err", err, m_err);
        end
    end

    task automatic wait_done(input int poke, output int lat);
        lat = 0;
        while (!done && lat < 1000) begin
            @(negedge clk);
            lat++;
            if (poke == 1 && lat == 5) begin
                start = 1; msg = 8'd3; expo = 8'd9; mod_n = 8'd11;
            end else if (poke == 1 && lat == 6) begin
                start = 0;
            end
            if (poke == 2 && lat == 10) begin
                rst_n = 0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_result", result, 0);
                check("rst_err", err, 0);
                repeat (2) @(negedge clk);
                check("rst_nodone", done, 0);
                rst_n = 1;
                lat = -1;
                return;
            end
        end
        if (lat >= 1000) check("timeout", lat, 0);
    endtask

    task automatic run_job(input int m, input int e, input int n,
                           input int poke, output int lat);
        @(negedge clk);
        msg = m[7:0]; expo = e[7:0]; mod_n = n[7:0];
        start = 1;
        @(negedge clk);
        start = 0;
        msg = 8'($urandom); expo = 8'($urandom); mod_n = 8'($urandom);
        wait_done(poke, lat);
        if (poke == 1 && lat >= 0) begin
            start = 1;
            @(negedge clk);
            start = 0;
        end
    endtask

    int lat;

    initial begin
        #2 rst_n = 0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        check("model_13", ref_res(13, 7, 33), 7);
        check("model_lat255", ref_lat(254, 255, 255), 137);

        run_job(7, 3, 33, 0, lat);
        check("enc_lat", lat, 35); check("enc_res", result, 13); check("enc_err", err, 0);
        run_job(13, 7, 33, 0, lat);
        check("dec_lat", lat, 52); check("dec_res", result, 7);
        run_job(5, 0, 33, 0, lat);
        check("exp0_lat", lat, 1); check("exp0_res", result, 1);
        run_job(254, 255, 255, 0, lat);
        check("big_lat", lat, 137); check("big_res", result, 254);
        run_job(9, 5, 1, 0, lat);
        check("n1_lat", lat, 1); check("n1_err", err, 1); check("n1_res", result, 0);
        run_job(40, 3, 33, 0, lat);
        check("msgbig_err", err, 1);
        run_job(7, 3, 33, 0, lat);
        check("clear_err", err, 0); check("clear_res", result, 13);

        run_job(7, 3, 33, 1, lat);
        check("poke_lat", lat, 35); check("poke_res", result, 13);

        // back-to-back: start held through DONE, accepted after one IDLE cycle
        run_job(7, 3, 33, 0, lat);
        msg = 8'd2; expo = 8'd5; mod_n = 8'd33; start = 1;
        @(negedge clk);
        check("b2b_idle", busy, 0);
        @(negedge clk);
        start = 0;
        check("b2b_busy", busy, 1);
        wait_done(0, lat);
        check("b2b_lat", lat, 44); check("b2b_res", result, 32);

        run_job(13, 7, 33, 2, lat);
        check("rst_abort", lat, -1);
        run_job(13, 7, 33, 0, lat);
        check("rerun_lat", lat, 52); check("rerun_res", result, 7);

        for (int j = 0; j < 60; j++) begin
            int n, m, e;
            n = $urandom_range(0, 255);
            if ($urandom_range(0, 9) == 0 || n == 0) m = $urandom_range(0, 255);
            else m = $urandom_range(0, n - 1);
            e = $urandom_range(0, 255);
            run_job(m, e, n, 0, lat);
            check("rnd_lat", lat, ref_lat(m, e, n));
            check("rnd_res", result, ref_res(m, e, n));
            check("rnd_err", err, int'(ref_err(m, n)));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
